// File: rtl/t_counter_pkg.sv
// Shared types, limits and helpers for the t_counter toggle-cell counter.
package t_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int WIDTH_MAX = 32;

  // Out-of-range load values clamp to the top of the count range.
  function automatic logic [WIDTH_MAX-1:0] clamp_load(
    input logic [WIDTH_MAX-1:0] val,
    input logic [WIDTH_MAX:0]   modulus
  );
    if ({1'b0, val} < modulus) return val;
    return modulus[WIDTH_MAX-1:0] - 32'd1;
  endfunction

endpackage

// File: rtl/t_cell.sv
// One counter bit: a toggle flip-flop with synchronous reset and parallel load.
module t_cell (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic ld,
  input  logic ld_val,
  input  logic t,
  output logic q
);

  logic q_d;
  logic q_q;

  // NOTE: q_d gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    q_d = q_q;
    if (ld)     q_d = ld_val;
    else if (t) q_d = ~q_q;
  end

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) q_q <= rst_val;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/t_counter.sv
// Up/down modulo-N counter built from per-bit toggle cells, with load, tc and wrap.
// Define T_COUNTER_SAT_EN to make the counter saturate at its boundaries instead of wrapping.
module t_counter
  import t_counter_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter longint unsigned MODULUS   = 256,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX || MODULUS < 2 ||
      MODULUS > (64'd1 << WIDTH) || RESET_VAL >= MODULUS) begin : g_param_check
    $error("t_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
  end

  localparam logic [WIDTH-1:0]   MAX_VAL = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0]   RST_Q   = WIDTH'(RESET_VAL);
  localparam logic [WIDTH_MAX:0] MOD_EXT = (WIDTH_MAX + 1)'(MODULUS);

  dir_e             dir;
  logic             at_max;
  logic             at_zero;
  logic             boundary;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] ld_val_c;
  logic [WIDTH-1:0] tgl;
  logic             wrap_d;
  logic             wrap_q;

  assign dir      = dir_e'(up);
  assign at_max   = (q == MAX_VAL);
  assign at_zero  = (q == '0);
  assign boundary = (dir == DIR_UP) ? at_max : at_zero;
  assign tc       = boundary;
  assign ld_val_c = WIDTH'(clamp_load(WIDTH_MAX'(load_val), MOD_EXT));

  // The modulus boundary is an explicit compare so non-power-of-two ranges work.
  always_comb begin
    cnt_next = q;
    wrap_d   = 1'b0;
    if (load) begin
      wrap_d = 1'b0;
    end else if (en) begin
      wrap_d = boundary;
      if (boundary) begin
`ifdef T_COUNTER_SAT_EN
        cnt_next = q;
`else
        cnt_next = (dir == DIR_UP) ? '0 : MAX_VAL;
`endif
      end else begin
        cnt_next = (dir == DIR_UP) ? q + 1'b1 : q - 1'b1;
      end
    end
  end

  assign tgl = q ^ cnt_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_cell u_cell (
      .clk    (clk),
      .reset  (reset),
      .rst_val(RST_Q[i]),
      .ld     (load),
      .ld_val (ld_val_c[i]),
      .t      (tgl[i]),
      .q      (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) wrap_q <= 1'b0;
    else       wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_t_counter.sv
// Directed bench for t_counter: three configurations share one stimulus stream and
// are checked every cycle against an arithmetic model plus hand-computed values.
module tb_t_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] q0, q1;
  logic [0:0] q2;
  logic       tc0, tc1, tc2;
  logic       wrap0, wrap1, wrap2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  t_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .q(q0), .tc(tc0), .wrap(wrap0));

  t_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3)) u_dut_rv3 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .q(q1), .tc(tc1), .wrap(wrap1));

  t_counter #(.WIDTH(1), .MODULUS(2), .RESET_VAL(0)) u_dut_m2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val[0:0]), .q(q2), .tc(tc2), .wrap(wrap2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counts in plain integers, one entry per instance.
  int  w_a[3]   = '{4, 4, 1};
  int  mod_a[3] = '{10, 10, 2};
  int  rv_a[3]  = '{0, 3, 0};
  int  m_q[3];
  int  m_w[3];
  bit  valid = 1'b0;
`ifdef T_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always @(posedge clk) begin
    int lv;
    for (int k = 0; k < 3; k++) begin
      lv = int'(load_val) % (1 << w_a[k]);
      if (reset) begin
        m_q[k] = rv_a[k];
        m_w[k] = 0;
      end else if (load) begin
        m_q[k] = (lv < mod_a[k]) ? lv : mod_a[k] - 1;
        m_w[k] = 0;
      end else if (en) begin
        if (up && m_q[k] == mod_a[k] - 1) begin
          m_w[k] = 1;
          m_q[k] = SAT ? m_q[k] : 0;
        end else if (!up && m_q[k] == 0) begin
          m_w[k] = 1;
          m_q[k] = SAT ? 0 : mod_a[k] - 1;
        end else begin
          m_w[k] = 0;
          m_q[k] = up ? m_q[k] + 1 : m_q[k] - 1;
        end
      end else begin
        m_w[k] = 0;
      end
    end
    if (reset) valid = 1'b1;
  end

  always @(negedge clk) begin
    if (valid) begin
      check("m0_q",    32'(q0),    32'(m_q[0]));
      check("m0_wrap", 32'(wrap0), 32'(m_w[0]));
      check("m0_tc",   32'(tc0),   32'(up ? (m_q[0] == 9) : (m_q[0] == 0)));
      check("m1_q",    32'(q1),    32'(m_q[1]));
      check("m1_wrap", 32'(wrap1), 32'(m_w[1]));
      check("m1_tc",   32'(tc1),   32'(up ? (m_q[1] == 9) : (m_q[1] == 0)));
      check("m2_q",    32'(q2),    32'(m_q[2]));
      check("m2_wrap", 32'(wrap2), 32'(m_w[2]));
      check("m2_tc",   32'(tc2),   32'(up ? (m_q[2] == 1) : (m_q[2] == 0)));
    end
  end

  task automatic step(input logic r, input logic l, input logic e, input logic u,
                      input logic [3:0] lv);
    reset = r; load = l; en = e; up = u; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_q;
    int dn_exp[4];

    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check("rst_q0", 32'(q0), 0);
    check("rst_q1", 32'(q1), 3);
    check("rst_wrap0", 32'(wrap0), 0);
    check("rst_tc0", 32'(tc0), 0);

    // Up count from 0: 1..9, 0, 1, 2 (saturating build sticks at 9).
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 1, 1, 0);
      exp_q = SAT ? ((k > 9) ? 9 : k) : k % 10;
      check("up_q", 32'(q0), 32'(exp_q));
      check("up_wrap", 32'(wrap0), 32'(SAT ? (k >= 10) : (k == 10)));
      check("up_tc", 32'(tc0), 32'(exp_q == 9));
    end

    // Down count from a load of 2: 1, 0, 9, 8 (saturating build sticks at 0).
    step(0, 1, 0, 1, 2);
    check("load2_q", 32'(q0), 2);
    dn_exp = SAT ? '{1, 0, 0, 0} : '{1, 0, 9, 8};
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 0, 0);
      check("dn_q", 32'(q0), 32'(dn_exp[k]));
      check("dn_wrap", 32'(wrap0), 32'(SAT ? (k >= 2) : (k == 2)));
      check("dn_tc", 32'(tc0), 32'(dn_exp[k] == 0));
    end

    // tc follows up immediately, without a clock edge.
    step(0, 1, 0, 0, 0);
    check("dir_tc_down", 32'(tc0), 1);
    up = 1'b1;
    #1;
    check("dir_tc_up", 32'(tc0), 0);
    up = 1'b0;
    #1;
    check("dir_tc_down2", 32'(tc0), 1);

    // Load clamping and load-over-en priority.
    step(0, 1, 0, 1, 13);
    check("clamp_q", 32'(q0), 9);
    check("clamp_tc", 32'(tc0), 1);
    step(0, 1, 1, 1, 5);
    check("ld_en_q", 32'(q0), 5);
    check("ld_en_wrap", 32'(wrap0), 0);

    // Reset mid-count overrides load and en; RESET_VAL=3 instance resumes at 4, 5.
    step(0, 0, 1, 1, 0);
    check("pre_rst_q", 32'(q0), 6);
    step(1, 1, 1, 1, 7);
    check("midrst_q0", 32'(q0), 0);
    check("midrst_wrap0", 32'(wrap0), 0);
    check("midrst_q1", 32'(q1), 3);
    step(0, 0, 1, 1, 0);
    check("resume_q1a", 32'(q1), 4);
    step(0, 0, 1, 1, 0);
    check("resume_q1b", 32'(q1), 5);

    // Single-bit modulus-2 instance behaves as a toggle flip-flop.
    step(1, 0, 0, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 1, 1, 0);
      check("tff_q", 32'(q2), 32'(SAT ? 1 : k % 2));
      check("tff_wrap", 32'(wrap2), 32'(SAT ? (k >= 2) : (k % 2 == 0)));
    end
    step(0, 0, 0, 1, 0);
    check("hold_wrap2", 32'(wrap2), 0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
